// File: rtl/pifo_vq_scheduler.sv
// Round-robin front end sharing one multi-lane PIFO among requesters.
// Tracks per-tree occupancy, spaces lane ops and returns tagged responses.
module pifo_vq_scheduler #(
  parameter int NREQ    = 4,
  parameter int NTREE   = 4,
  parameter int PTW     = 8,
  parameter int CAP     = 16,
  parameter int OP_GAP  = 2,
  parameter int POP_LAT = 2,
  parameter int TIDW    = $clog2(NTREE),
  parameter int CNTW    = $clog2(CAP+1)
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  input  logic [NREQ-1:0] i_req_valid,
  output logic [NREQ-1:0] o_req_ready,
  input  logic [NREQ-1:0] i_req_op,
  input  logic [TIDW-1:0] i_req_tree [0:NREQ-1],
  input  logic [PTW-1:0]  i_req_data [0:NREQ-1],
  output logic [NREQ-1:0] o_rsp_valid,
  output logic [NREQ-1:0] o_rsp_err,
  output logic [PTW-1:0]  o_rsp_data [0:NREQ-1],
  output logic [NTREE-1:0] o_push,
  output logic [NTREE-1:0] o_pop,
  output logic [PTW-1:0]  o_push_data [0:NTREE-1],
  output logic [TIDW-1:0] o_tree_id [0:NTREE-1],
  input  logic [PTW-1:0]  i_pop_data [0:NTREE-1],
  output logic [CNTW-1:0] o_occ [0:NTREE-1]
);

  localparam int RIDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW   = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;

  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] granted;
  logic [NREQ-1:0] cmd_op;
  logic [TIDW-1:0] cmd_tree [NREQ];
  logic [PTW-1:0]  cmd_data [NREQ];

  logic [CNTW-1:0] occ  [NTREE];
  logic [GW-1:0]   gap  [NTREE];
  logic [RIDW-1:0] ptr  [NTREE];
  logic [POP_LAT:0] pv  [NTREE];
  logic [RIDW-1:0] pid  [NTREE][POP_LAT+1];

  logic [NTREE-1:0] gv;
  logic [NTREE-1:0] gop;
  logic [NTREE-1:0] gok;
  logic [RIDW-1:0]  gr [NTREE];

  logic [NREQ-1:0] won;
  logic [NREQ-1:0] rv_n;
  logic [NREQ-1:0] re_n;
  logic [PTW-1:0]  rd_n [NREQ];

  assign o_req_ready = ~busy;

  // Constant lane ids and occupancy view
  always_comb begin
    for (int t = 0; t < NTREE; t++) begin
      o_tree_id[t] = TIDW'(t);
      o_occ[t]     = occ[t];
    end
  end

  // Per-lane round-robin pick, starting from the pointer
  always_comb begin
    int idx;
    idx = 0;
    for (int t = 0; t < NTREE; t++) begin
      gv[t] = 1'b0;
      gr[t] = '0;
      if (gap[t] == '0) begin
        for (int o = 0; o < NREQ; o++) begin
          idx = (int'(ptr[t]) + o) % NREQ;
          if (!gv[t] && busy[idx] && !granted[idx] &&
              cmd_tree[idx] == TIDW'(t)) begin
            gv[t] = 1'b1;
            gr[t] = RIDW'(idx);
          end
        end
      end
      gop[t] = cmd_op[gr[t]];
      gok[t] = gop[t] ? (occ[t] != '0)
                      : (occ[t] < CNTW'(CAP));
    end
  end

  // Next-cycle responses: push/error at grant, pop at pipe exit
  always_comb begin
    won  = '0;
    rv_n = '0;
    re_n = '0;
    for (int r = 0; r < NREQ; r++) rd_n[r] = '0;
    for (int t = 0; t < NTREE; t++) begin
      if (gv[t]) begin
        won[gr[t]] = 1'b1;
        if (!gop[t] || !gok[t]) begin
          rv_n[gr[t]] = 1'b1;
          re_n[gr[t]] = ~gok[t];
        end
      end
      if (pv[t][POP_LAT]) begin
        rv_n[pid[t][POP_LAT]] = 1'b1;
        rd_n[pid[t][POP_LAT]] = i_pop_data[t];
      end
    end
  end

  // Requester command registers and busy/granted tracking
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      busy    <= '0;
      granted <= '0;
      cmd_op  <= '0;
      for (int r = 0; r < NREQ; r++) begin
        cmd_tree[r] <= '0;
        cmd_data[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        if (o_rsp_valid[r]) begin
          busy[r]    <= 1'b0;
          granted[r] <= 1'b0;
        end else begin
          if (i_req_valid[r] && !busy[r]) begin
            busy[r]     <= 1'b1;
            cmd_op[r]   <= i_req_op[r];
            cmd_tree[r] <= i_req_tree[r];
            cmd_data[r] <= i_req_data[r];
          end
          if (won[r]) granted[r] <= 1'b1;
        end
      end
    end
  end

  // Registered response outputs
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_rsp_valid <= '0;
      o_rsp_err   <= '0;
      for (int r = 0; r < NREQ; r++) o_rsp_data[r] <= '0;
    end else begin
      o_rsp_valid <= rv_n;
      o_rsp_err   <= re_n;
      for (int r = 0; r < NREQ; r++) o_rsp_data[r] <= rd_n[r];
    end
  end

  // Lane strobes, occupancy, spacing, pointers and pop pipes
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_push <= '0;
      o_pop  <= '0;
      for (int t = 0; t < NTREE; t++) begin
        o_push_data[t] <= '0;
        occ[t] <= '0;
        gap[t] <= '0;
        ptr[t] <= '0;
        pv[t]  <= '0;
        for (int s = 0; s <= POP_LAT; s++) pid[t][s] <= '0;
      end
    end else begin
      for (int t = 0; t < NTREE; t++) begin
        o_push[t] <= gv[t] & ~gop[t] & gok[t];
        o_pop[t]  <= gv[t] & gop[t] & gok[t];
        o_push_data[t] <= (gv[t] && !gop[t] && gok[t])
                          ? cmd_data[gr[t]] : '0;
        if (gv[t] && gok[t]) begin
          gap[t] <= GW'(OP_GAP - 1);
          if (gop[t]) occ[t] <= occ[t] - 1'b1;
          else        occ[t] <= occ[t] + 1'b1;
        end else if (gap[t] != '0) begin
          gap[t] <= gap[t] - 1'b1;
        end
        if (gv[t]) ptr[t] <= RIDW'((int'(gr[t]) + 1) % NREQ);
        pv[t] <= {pv[t][POP_LAT-1:0], gv[t] & gop[t] & gok[t]};
        pid[t][0] <= gr[t];
        for (int s = 1; s <= POP_LAT; s++) pid[t][s] <= pid[t][s-1];
      end
    end
  end

endmodule

// File: tb/tb_pifo_vq_scheduler.sv
// Directed bench for pifo_vq_scheduler with a timing-exact PIFO data model.
// Single-command table plus sequences for contention, fill and reset.
module tb_pifo_vq_scheduler;

  localparam int POP_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [3:0] req_op = '0;
  logic [1:0] req_tree [0:3];
  logic [7:0] req_data [0:3];
  logic [3:0] rsp_valid;
  logic [3:0] rsp_err;
  logic [7:0] rsp_data [0:3];
  logic [3:0] push;
  logic [3:0] pop;
  logic [7:0] push_data [0:3];
  logic [1:0] tree_id [0:3];
  logic [7:0] pop_data [0:3];
  logic [4:0] occ [0:3];

  pifo_vq_scheduler dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_tree(req_tree),
    .i_req_data(req_data), .o_rsp_valid(rsp_valid),
    .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
    .o_push(push), .o_pop(pop), .o_push_data(push_data),
    .o_tree_id(tree_id), .i_pop_data(pop_data), .o_occ(occ)
  );

  always #5 clk = ~clk;

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;

  logic [7:0] slot  [4][8];
  bit         slotv [4][8];
  int npop [4];
  int npush [4];
  int popcyc [4][32];

  bit         seen  [4];
  int         s_cyc [4];
  logic       s_err [4];
  logic [7:0] s_dat [4];

  typedef struct {
    int r; bit op; int tr; logic [7:0] d;
    bit err; logic [7:0] dat; int occ;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One clock; the PIFO model and response monitor run here
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int t = 0; t < 4; t++) begin
      pop_data[t] = slotv[t][cyc % 8] ? slot[t][cyc % 8] : 8'hEE;
      slotv[t][cyc % 8] = 1'b0;
      if (pop[t]) begin
        slot[t][(cyc + POP_LAT) % 8]  = 8'(64 * t + 1 + npop[t]);
        slotv[t][(cyc + POP_LAT) % 8] = 1'b1;
        popcyc[t][npop[t] % 32] = cyc;
        npop[t]++;
      end
      if (push[t]) npush[t]++;
    end
    for (int r = 0; r < 4; r++)
      if (rsp_valid[r]) begin
        seen[r]  = 1'b1;
        s_cyc[r] = cyc;
        s_err[r] = rsp_err[r];
        s_dat[r] = rsp_data[r];
      end
  endtask

  task automatic txn(input int r, input bit op, input int tr,
                     input logic [7:0] d, output int c0);
    int k = 0;
    while (!req_ready[r] && k < 20) begin tick(); k++; end
    if (k == 20) chk("ready_timeout", {31'd0, req_ready[r]}, 32'd1);
    seen[r] = 1'b0;
    req_valid[r] = 1'b1;
    req_op[r] = op;
    req_tree[r] = 2'(tr);
    req_data[r] = d;
    tick();
    req_valid[r] = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_rsp(input int r);
    int k = 0;
    while (!seen[r] && k < 20) begin tick(); k++; end
    if (!seen[r]) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c0, base, cnt, sv;
    int order [4];
    int iss [4];
    for (int i = 0; i < 4; i++) begin
      req_tree[i] = '0; req_data[i] = '0; pop_data[i] = 8'hEE;
      npop[i] = 0; npush[i] = 0; seen[i] = 0;
      for (int j = 0; j < 8; j++) slotv[i][j] = 0;
    end
    vecs[0] = '{2, 0, 2, 8'h50, 0, 8'h00, 2};
    vecs[1] = '{2, 0, 2, 8'h51, 0, 8'h00, 3};
    vecs[2] = '{3, 0, 2, 8'h52, 0, 8'h00, 4};
    vecs[3] = '{1, 1, 1, 8'h00, 0, 8'h41, 0};
    vecs[4] = '{3, 1, 1, 8'h00, 1, 8'h00, 0};
    vecs[5] = '{0, 1, 3, 8'h00, 0, 8'hC1, 0};
    vecs[6] = '{3, 0, 3, 8'h77, 0, 8'h00, 1};
    vecs[7] = '{0, 1, 3, 8'h00, 0, 8'hC2, 0};

    // Reset state
    tick(); tick();
    chk("rst_ready", {28'd0, req_ready}, 32'hF);
    rst_n = 1'b1;
    tick();
    chk("rst_ready2", {28'd0, req_ready}, 32'hF);
    chk("rst_strobes", {24'd0, push, pop}, 32'd0);
    chk("rst_rsp", {28'd0, rsp_valid}, 32'd0);
    for (int t = 0; t < 4; t++) begin
      chk("rst_occ", {27'd0, occ[t]}, 32'd0);
      chk("tree_id", {30'd0, tree_id[t]}, t);
    end

    // Parallel pushes, one per lane
    for (int r = 0; r < 4; r++) begin
      req_valid[r] = 1'b1; req_op[r] = 1'b0;
      req_tree[r] = 2'(r); req_data[r] = 8'(16 * r + 1);
    end
    tick();
    req_valid = '0;
    chk("par_busy", {28'd0, req_ready}, 32'd0);
    tick();
    chk("par_push", {28'd0, push}, 32'hF);
    chk("par_rsp", {28'd0, rsp_valid}, 32'hF);
    chk("par_err", {28'd0, rsp_err}, 32'd0);
    for (int t = 0; t < 4; t++) begin
      chk("par_pdata", {24'd0, push_data[t]}, 16 * t + 1);
      chk("par_occ", {27'd0, occ[t]}, 32'd1);
    end
    tick();
    chk("par_ready", {28'd0, req_ready}, 32'hF);
    chk("par_rsp_end", {28'd0, rsp_valid}, 32'd0);

    // Single-command table
    for (int i = 0; i < 8; i++) begin
      sv = vecs[i].op ? npop[vecs[i].tr] : npush[vecs[i].tr];
      txn(vecs[i].r, vecs[i].op, vecs[i].tr, vecs[i].d, c0);
      wait_rsp(vecs[i].r);
      chk($sformatf("v%0d_err", i), {31'd0, s_err[vecs[i].r]},
          {31'd0, vecs[i].err});
      chk($sformatf("v%0d_data", i), {24'd0, s_dat[vecs[i].r]},
          {24'd0, vecs[i].dat});
      chk($sformatf("v%0d_occ", i), {27'd0, occ[vecs[i].tr]},
          vecs[i].occ);
      chk($sformatf("v%0d_lat", i), s_cyc[vecs[i].r] - c0,
          (vecs[i].op && !vecs[i].err) ? POP_LAT + 2 : 1);
      chk($sformatf("v%0d_strobe", i),
          (vecs[i].op ? npop[vecs[i].tr] : npush[vecs[i].tr]) - sv,
          vecs[i].err ? 0 : 1);
      tick();
    end

    // Four pops on tree 2 in one cycle: RR order and lane spacing
    chk("d_occ_pre", {27'd0, occ[2]}, 32'd4);
    base = npop[2];
    for (int r = 0; r < 4; r++) begin
      seen[r] = 0; req_valid[r] = 1'b1;
      req_op[r] = 1'b1; req_tree[r] = 2'd2;
    end
    tick();
    req_valid = '0;
    cnt = 0;
    while (!(seen[0] && seen[1] && seen[2] && seen[3]) && cnt < 30) begin
      tick(); cnt++;
    end
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("d_seen%0d", r), {31'd0, seen[r]}, 32'd1);
      chk($sformatf("d_data%0d", r), {24'd0, s_dat[r]}, 8'h81 + r);
      chk($sformatf("d_err%0d", r), {31'd0, s_err[r]}, 32'd0);
      chk($sformatf("d_lat%0d", r),
          s_cyc[r] - popcyc[2][(base + r) % 32], POP_LAT + 1);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("d_gap%0d", i),
          popcyc[2][(base + i + 1) % 32] - popcyc[2][(base + i) % 32], 2);
    chk("d_occ", {27'd0, occ[2]}, 32'd0);
    tick();

    // Fill tree 0 to capacity, then overflow
    for (int i = 0; i < 15; i++) begin
      txn(0, 1'b0, 0, 8'(i), c0);
      wait_rsp(0);
    end
    chk("f_occ16", {27'd0, occ[0]}, 32'd16);
    sv = npush[0];
    txn(0, 1'b0, 0, 8'hAA, c0);
    wait_rsp(0);
    chk("f_err", {31'd0, s_err[0]}, 32'd1);
    chk("f_data", {24'd0, s_dat[0]}, 32'd0);
    chk("f_nopush", npush[0] - sv, 0);
    chk("f_occ", {27'd0, occ[0]}, 32'd16);
    tick();

    // Requesters 1 and 3 contend on tree 0
    iss[1] = 0; iss[3] = 0; cnt = 0; c0 = 0;
    seen[1] = 0; seen[3] = 0;
    while (cnt < 4 && c0 < 60) begin
      for (int r = 1; r < 4; r += 2)
        if (req_ready[r] && iss[r] < 2) begin
          req_valid[r] = 1'b1; req_op[r] = 1'b1;
          req_tree[r] = 2'd0; iss[r]++;
        end
      tick();
      req_valid = '0;
      c0++;
      for (int r = 1; r < 4; r += 2)
        if (seen[r]) begin
          if (cnt < 4) order[cnt] = r;
          cnt++;
          seen[r] = 0;
        end
    end
    chk("c_count", cnt, 4);
    chk("c_o0", order[0], 1);
    chk("c_o1", order[1], 3);
    chk("c_o2", order[2], 1);
    chk("c_o3", order[3], 3);
    chk("c_occ", {27'd0, occ[0]}, 32'd12);
    tick(); tick();

    // Reset with two pops in flight
    sv = npop[0];
    req_valid[0] = 1'b1; req_op[0] = 1'b1; req_tree[0] = 2'd0;
    req_valid[2] = 1'b1; req_op[2] = 1'b1; req_tree[2] = 2'd0;
    tick();
    req_valid = '0;
    cnt = 0;
    while (npop[0] - sv < 2 && cnt < 20) begin tick(); cnt++; end
    chk("r_two_pops", npop[0] - sv, 2);
    rst_n = 1'b0;
    #1;
    chk("r_async_ready", {28'd0, req_ready}, 32'hF);
    for (int r = 0; r < 4; r++) seen[r] = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("r_norsp", {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'd0);
    chk("r_ready", {28'd0, req_ready}, 32'hF);
    for (int t = 0; t < 4; t++)
      chk("r_occ", {27'd0, occ[t]}, 32'd0);
    txn(0, 1'b1, 1, 8'h00, c0);
    wait_rsp(0);
    chk("r_pop_err", {31'd0, s_err[0]}, 32'd1);
    chk("r_pop_data", {24'd0, s_dat[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
